retire_unit: RTL and testbench

- Commit stage at the head end of the reorder buffer.
- Each cycle it inspects the two oldest ROB entries and retires up to two completed instructions in order, popping them with rd1/rd2 (the ROB's dout1_req/dout2_req).
- For each retiring register writer it updates the architectural map and returns the previous physical register to the free list.
- Starts mispredict recovery (flush plus redirect) and stops retirement on halt.

---
 rtl/retire_unit_if.sv | 55 +++++
 rtl/retire_unit.sv | 168 ++++++++++++++++
 tb/tb_retire_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_unit_if.sv
// Retire unit bus: ROB head entries in, pop strobes and commit side effects out.
// master = retire unit, slave = ROB / map / free-list side.
// RETIRE_STALL_CNT_EN adds stall_count to the bundle.
interface retire_unit_if #(
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
);
  logic               head1_valid, head1_done, head1_bmisp, head1_halt, head1_wr;
  logic [ARF_IDX-1:0] head1_ard;
  logic [PRF_IDX-1:0] head1_pdest, head1_pold;
  logic [63:0]        head1_btarget;
  logic               head2_valid, head2_done, head2_bmisp, head2_halt, head2_wr;
  logic [ARF_IDX-1:0] head2_ard;
  logic [PRF_IDX-1:0] head2_pdest, head2_pold;
  logic [63:0]        head2_btarget;

  logic               rd1, rd2;
  logic               amt_we1, amt_we2;
  logic [ARF_IDX-1:0] amt_idx1, amt_idx2;
  logic [PRF_IDX-1:0] amt_preg1, amt_preg2;
  logic               free_en1, free_en2;
  logic [PRF_IDX-1:0] free_preg1, free_preg2;
  logic               flush, redirect_en, halted;
  logic [63:0]        redirect_pc;
  logic [31:0]        retire_count;
`ifdef RETIRE_STALL_CNT_EN
  logic [31:0]        stall_count;
`endif

  modport master (
    input  head1_valid, head1_done, head1_bmisp, head1_halt, head1_wr,
           head1_ard, head1_pdest, head1_pold, head1_btarget,
           head2_valid, head2_done, head2_bmisp, head2_halt, head2_wr,
           head2_ard, head2_pdest, head2_pold, head2_btarget,
    output rd1, rd2, amt_we1, amt_we2, amt_idx1, amt_idx2, amt_preg1, amt_preg2,
           free_en1, free_en2, free_preg1, free_preg2,
           flush, redirect_en, redirect_pc, halted, retire_count
`ifdef RETIRE_STALL_CNT_EN
    , output stall_count
`endif
  );

  modport slave (
    output head1_valid, head1_done, head1_bmisp, head1_halt, head1_wr,
           head1_ard, head1_pdest, head1_pold, head1_btarget,
           head2_valid, head2_done, head2_bmisp, head2_halt, head2_wr,
           head2_ard, head2_pdest, head2_pold, head2_btarget,
    input  rd1, rd2, amt_we1, amt_we2, amt_idx1, amt_idx2, amt_preg1, amt_preg2,
           free_en1, free_en2, free_preg1, free_preg2,
           flush, redirect_en, redirect_pc, halted, retire_count
`ifdef RETIRE_STALL_CNT_EN
    , input stall_count
`endif
  );
endinterface

// File: rtl/retire_unit.sv
// In-order dual-slot commit stage at the ROB head.
// Pops up to two completed entries per cycle, updates the architectural map,
// frees old physical registers, starts mispredict flush/redirect, stops on halt.
// Optional: RETIRE_STALL_CNT_EN adds stall_count (RUN cycles with head1 valid, not done).

// Per-slot map/free write decode.
module retire_slot #(
  parameter int PRF_IDX = 6,
  parameter int ARF_IDX = 5
) (
  input  logic               rd,
  input  logic               wr,
  input  logic [ARF_IDX-1:0] ard,
  input  logic [PRF_IDX-1:0] pdest,
  input  logic [PRF_IDX-1:0] pold,
  output logic               we,
  output logic [ARF_IDX-1:0] idx,
  output logic [PRF_IDX-1:0] map_preg,
  output logic [PRF_IDX-1:0] free_preg
);
  // All-ones arch index is the zero register: retires without touching map or free list.
  assign we        = rd & wr & (ard != '1);
  assign idx       = we ? ard   : '0;
  assign map_preg  = we ? pdest : '0;
  assign free_preg = we ? pold  : '0;
endmodule

module retire_unit #(
  parameter int PRF_IDX      = 6,
  parameter int ARF_IDX      = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  retire_unit_if.master bus
);
  localparam int       NUM_LANES  = 2;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       ok1, ok2, rd1, rd2, misp, halt_ret;
  logic [63:0] redir_pc;

  logic [NUM_LANES-1:0]              rd_v, wr_v, we_v;
  logic [NUM_LANES-1:0][ARF_IDX-1:0] ard_v, idx_v;
  logic [NUM_LANES-1:0][PRF_IDX-1:0] pdest_v, pold_v, map_v, free_v;
  logic                              same_dest;

  // Slot2 is only eligible behind a clean, completed slot1.
  assign ok1 = bus.head1_valid & bus.head1_done;
  assign ok2 = ok1 & ~bus.head1_bmisp & ~bus.head1_halt & bus.head2_valid & bus.head2_done;

  // State and flush countdown.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end

  // Retire decision (RUN only), recovery/halt sequencing.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    rd1       = 1'b0;
    rd2       = 1'b0;
    misp      = 1'b0;
    halt_ret  = 1'b0;
    redir_pc  = '0;
    case (state)
      RUN: begin
        rd1      = ok1;
        rd2      = ok2;
        misp     = (ok1 & bus.head1_bmisp) | (ok2 & bus.head2_bmisp);
        halt_ret = (ok1 & bus.head1_halt)  | (ok2 & bus.head2_halt);
        redir_pc = (ok1 & bus.head1_bmisp) ? bus.head1_btarget : bus.head2_btarget;
        if (misp) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LAST;
        end else if (halt_ret) begin
          state_nxt = HALTED;
        end
      end
      // A halt that also mispredicted is already latched in halted; park after the flush.
      FLUSH: begin
        if (fcnt == 4'd0) state_nxt = bus.halted ? HALTED : RUN;
        else              fcnt_nxt  = fcnt - 4'd1;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.rd1 = rd1;
  assign bus.rd2 = rd2;

  assign rd_v    = {rd2, rd1};
  assign wr_v    = {bus.head2_wr, bus.head1_wr};
  assign ard_v   = {bus.head2_ard, bus.head1_ard};
  assign pdest_v = {bus.head2_pdest, bus.head1_pdest};
  assign pold_v  = {bus.head2_pold, bus.head1_pold};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    retire_slot #(.PRF_IDX(PRF_IDX), .ARF_IDX(ARF_IDX)) u_slot (
      .rd       (rd_v[i]),
      .wr       (wr_v[i]),
      .ard      (ard_v[i]),
      .pdest    (pdest_v[i]),
      .pold     (pold_v[i]),
      .we       (we_v[i]),
      .idx      (idx_v[i]),
      .map_preg (map_v[i]),
      .free_preg(free_v[i])
    );
  end

  // Younger slot owns the final mapping; older map write is redundant.
  assign same_dest = &we_v & (ard_v[0] == ard_v[1]);

  // Commit side effects, one cycle after the pop.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.amt_we1      <= 1'b0;
      bus.amt_we2      <= 1'b0;
      bus.amt_idx1     <= '0;
      bus.amt_idx2     <= '0;
      bus.amt_preg1    <= '0;
      bus.amt_preg2    <= '0;
      bus.free_en1     <= 1'b0;
      bus.free_en2     <= 1'b0;
      bus.free_preg1   <= '0;
      bus.free_preg2   <= '0;
      bus.flush        <= 1'b0;
      bus.redirect_en  <= 1'b0;
      bus.redirect_pc  <= '0;
      bus.halted       <= 1'b0;
      bus.retire_count <= '0;
    end else begin
      bus.amt_we1      <= we_v[0] & ~same_dest;
      bus.amt_we2      <= we_v[1];
      bus.amt_idx1     <= same_dest ? '0 : idx_v[0];
      bus.amt_idx2     <= idx_v[1];
      bus.amt_preg1    <= same_dest ? '0 : map_v[0];
      bus.amt_preg2    <= map_v[1];
      bus.free_en1     <= we_v[0];
      bus.free_en2     <= we_v[1];
      bus.free_preg1   <= free_v[0];
      bus.free_preg2   <= free_v[1];
      bus.flush        <= (state_nxt == FLUSH);
      bus.redirect_en  <= misp;
      bus.redirect_pc  <= misp ? redir_pc : '0;
      bus.halted       <= bus.halted | halt_ret;
      bus.retire_count <= bus.retire_count + {31'd0, rd1} + {31'd0, rd2};
    end

`ifdef RETIRE_STALL_CNT_EN
  // Head blocked on an incomplete instruction while retirement is live.
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.stall_count <= '0;
    else if (state == RUN && bus.head1_valid && !bus.head1_done)
      bus.stall_count <= bus.stall_count + 32'd1;
`endif
endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: dual/partial retire, same-dest merge,
// mispredict flush/redirect, halt, zero register, async reset.
module tb_retire_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  retire_unit_if #(.PRF_IDX(6), .ARF_IDX(5)) bus ();

  retire_unit #(.PRF_IDX(6), .ARF_IDX(5), .FLUSH_CYCLES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic set_h1(input logic v, d, bm, h, w, input logic [4:0] ard,
                        input logic [5:0] pd, po, input logic [63:0] bt);
    bus.head1_valid = v; bus.head1_done = d; bus.head1_bmisp = bm; bus.head1_halt = h;
    bus.head1_wr = w; bus.head1_ard = ard; bus.head1_pdest = pd; bus.head1_pold = po;
    bus.head1_btarget = bt;
  endtask

  task automatic set_h2(input logic v, d, bm, h, w, input logic [4:0] ard,
                        input logic [5:0] pd, po, input logic [63:0] bt);
    bus.head2_valid = v; bus.head2_done = d; bus.head2_bmisp = bm; bus.head2_halt = h;
    bus.head2_wr = w; bus.head2_ard = ard; bus.head2_pdest = pd; bus.head2_pold = po;
    bus.head2_btarget = bt;
  endtask

  task automatic clear_heads();
    set_h1(0, 0, 0, 0, 0, 5'd0, 6'd0, 6'd0, 64'd0);
    set_h2(0, 0, 0, 0, 0, 5'd0, 6'd0, 6'd0, 64'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_heads();
    #12;
    checks++;
    if ({bus.rd1, bus.rd2, bus.amt_we1, bus.amt_we2, bus.free_en1, bus.free_en2,
         bus.flush, bus.redirect_en, bus.halted} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {bus.rd1, bus.rd2, bus.amt_we1, bus.amt_we2, bus.free_en1, bus.free_en2,
         bus.flush, bus.redirect_en, bus.halted});
    end
    checks++;
    if ({bus.retire_count, bus.redirect_pc} !== 96'd0) begin
      errors++; $display("FAIL reset_data: count %0d pc %0h expected 0", bus.retire_count, bus.redirect_pc);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_dual_retire();
    @(negedge clk);
    set_h1(1, 1, 0, 0, 1, 5'd3, 6'd10, 6'd20, 64'd0);
    set_h2(1, 1, 0, 0, 1, 5'd4, 6'd11, 6'd21, 64'd0);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b11) begin
      errors++; $display("FAIL dual_rd: got %b expected 11", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 2;
    checks++;
    if ({bus.amt_we1, bus.amt_idx1, bus.amt_preg1, bus.amt_we2, bus.amt_idx2, bus.amt_preg2}
        !== {1'b1, 5'd3, 6'd10, 1'b1, 5'd4, 6'd11}) begin
      errors++; $display("FAIL dual_amt: we %b%b idx %0d/%0d preg %0d/%0d expected 1,1 3/4 10/11",
        bus.amt_we1, bus.amt_we2, bus.amt_idx1, bus.amt_idx2, bus.amt_preg1, bus.amt_preg2);
    end
    checks++;
    if ({bus.free_en1, bus.free_preg1, bus.free_en2, bus.free_preg2} !== {1'b1, 6'd20, 1'b1, 6'd21}) begin
      errors++; $display("FAIL dual_free: en %b%b preg %0d/%0d expected 11 20/21",
        bus.free_en1, bus.free_en2, bus.free_preg1, bus.free_preg2);
    end
    checks++;
    if (bus.retire_count !== exp_cnt) begin
      errors++; $display("FAIL dual_count: got %0d expected %0d", bus.retire_count, exp_cnt);
    end
  endtask

  task automatic test_partial();
    @(negedge clk);
    set_h1(1, 1, 0, 0, 1, 5'd1, 6'd30, 6'd31, 64'd0);
    set_h2(1, 0, 0, 0, 1, 5'd2, 6'd32, 6'd33, 64'd0);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b10) begin
      errors++; $display("FAIL partial_rd: got %b expected 10", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 1;
    checks++;
    if ({bus.retire_count, bus.amt_we1, bus.amt_we2} !== {exp_cnt, 2'b10}) begin
      errors++; $display("FAIL partial_count: count %0d we %b%b expected %0d 10",
        bus.retire_count, bus.amt_we1, bus.amt_we2, exp_cnt);
    end
    @(negedge clk);
    set_h1(1, 1, 0, 0, 1, 5'd2, 6'd32, 6'd33, 64'd0);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b10) begin
      errors++; $display("FAIL partial_rd2: got %b expected 10", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 1;
    checks++;
    if ({bus.retire_count, bus.amt_we1, bus.amt_idx1, bus.amt_preg1, bus.free_preg1}
        !== {exp_cnt, 1'b1, 5'd2, 6'd32, 6'd33}) begin
      errors++; $display("FAIL partial_second: count %0d we %b idx %0d preg %0d free %0d expected %0d 1 2 32 33",
        bus.retire_count, bus.amt_we1, bus.amt_idx1, bus.amt_preg1, bus.free_preg1, exp_cnt);
    end
  endtask

  task automatic test_same_dest();
    @(negedge clk);
    set_h1(1, 1, 0, 0, 1, 5'd7, 6'd12, 6'd5, 64'd0);
    set_h2(1, 1, 0, 0, 1, 5'd7, 6'd13, 6'd12, 64'd0);
    @(posedge clk); #1; clear_heads(); exp_cnt += 2;
    checks++;
    if ({bus.amt_we1, bus.amt_we2, bus.amt_idx2, bus.amt_preg2} !== {1'b0, 1'b1, 5'd7, 6'd13}) begin
      errors++; $display("FAIL same_amt: we %b%b idx2 %0d preg2 %0d expected 01 7 13",
        bus.amt_we1, bus.amt_we2, bus.amt_idx2, bus.amt_preg2);
    end
    checks++;
    if ({bus.free_en1, bus.free_preg1, bus.free_en2, bus.free_preg2} !== {1'b1, 6'd5, 1'b1, 6'd12}) begin
      errors++; $display("FAIL same_free: en %b%b preg %0d/%0d expected 11 5/12",
        bus.free_en1, bus.free_en2, bus.free_preg1, bus.free_preg2);
    end
  endtask

  task automatic test_mispredict();
    @(negedge clk);
    set_h1(1, 1, 1, 0, 1, 5'd8, 6'd14, 6'd15, 64'h1000);
    set_h2(1, 1, 0, 0, 1, 5'd9, 6'd16, 6'd17, 64'h0);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b10) begin
      errors++; $display("FAIL misp_rd: got %b expected 10", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; exp_cnt += 1;
    set_h1(1, 1, 0, 0, 1, 5'd10, 6'd18, 6'd19, 64'd0);
    set_h2(1, 1, 0, 0, 1, 5'd9, 6'd16, 6'd17, 64'd0);
    #1; checks++;
    if ({bus.redirect_en, bus.redirect_pc, bus.flush, bus.rd1, bus.rd2, bus.amt_we1}
        !== {1'b1, 64'h1000, 1'b1, 2'b00, 1'b1}) begin
      errors++; $display("FAIL misp_first: redir %b pc %0h flush %b rd %b%b we1 %b expected 1 1000 1 00 1",
        bus.redirect_en, bus.redirect_pc, bus.flush, bus.rd1, bus.rd2, bus.amt_we1);
    end
    @(posedge clk); #1; checks++;
    if ({bus.redirect_en, bus.flush, bus.rd1, bus.rd2} !== 4'b0100) begin
      errors++; $display("FAIL misp_second: redir %b flush %b rd %b%b expected 0 1 00",
        bus.redirect_en, bus.flush, bus.rd1, bus.rd2);
    end
    @(posedge clk); #1; checks++;
    if ({bus.flush, bus.rd1, bus.rd2, bus.retire_count} !== {3'b011, exp_cnt}) begin
      errors++; $display("FAIL misp_resume: flush %b rd %b%b count %0d expected 0 11 %0d",
        bus.flush, bus.rd1, bus.rd2, bus.retire_count, exp_cnt);
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 2;
    checks++;
    if ({bus.retire_count, bus.amt_idx1, bus.amt_idx2} !== {exp_cnt, 5'd10, 5'd9}) begin
      errors++; $display("FAIL misp_after: count %0d idx %0d/%0d expected %0d 10/9",
        bus.retire_count, bus.amt_idx1, bus.amt_idx2, exp_cnt);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    set_h1(1, 1, 0, 0, 1, 5'd31, 6'd1, 6'd2, 64'd0);
    set_h2(0, 1, 1, 1, 1, 5'd5, 6'd3, 6'd4, 64'hdead);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b10) begin
      errors++; $display("FAIL zero_rd: got %b expected 10", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 1;
    checks++;
    if ({bus.amt_we1, bus.amt_we2, bus.free_en1, bus.free_en2, bus.redirect_en, bus.halted,
         bus.retire_count} !== {6'b000000, exp_cnt}) begin
      errors++; $display("FAIL zero_write: we %b%b free %b%b redir %b halt %b count %0d expected 000000 %0d",
        bus.amt_we1, bus.amt_we2, bus.free_en1, bus.free_en2, bus.redirect_en, bus.halted,
        bus.retire_count, exp_cnt);
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    set_h1(1, 1, 0, 1, 1, 5'd6, 6'd16, 6'd17, 64'd0);
    set_h2(1, 1, 0, 0, 1, 5'd9, 6'd20, 6'd21, 64'd0);
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b10) begin
      errors++; $display("FAIL halt_rd: got %b expected 10", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; exp_cnt += 1;
    set_h1(1, 1, 0, 0, 1, 5'd9, 6'd20, 6'd21, 64'd0);
    set_h2(1, 1, 0, 0, 1, 5'd11, 6'd22, 6'd23, 64'd0);
    #1; checks++;
    if ({bus.halted, bus.amt_we1, bus.rd1, bus.rd2, bus.retire_count} !== {4'b1100, exp_cnt}) begin
      errors++; $display("FAIL halt_enter: halted %b we1 %b rd %b%b count %0d expected 1 1 00 %0d",
        bus.halted, bus.amt_we1, bus.rd1, bus.rd2, bus.retire_count, exp_cnt);
    end
    repeat (3) @(posedge clk);
    #1; checks++;
    if ({bus.halted, bus.rd1, bus.rd2, bus.amt_we1, bus.retire_count} !== {4'b1000, exp_cnt}) begin
      errors++; $display("FAIL halt_hold: halted %b rd %b%b we1 %b count %0d expected 1 00 0 %0d",
        bus.halted, bus.rd1, bus.rd2, bus.amt_we1, bus.retire_count, exp_cnt);
    end
    #2; reset = 1'b0; exp_cnt = 0;
    #1; checks++;
    if ({bus.halted, bus.flush, bus.retire_count} !== 34'd0) begin
      errors++; $display("FAIL halt_async_reset: halted %b flush %b count %0d expected 0 0 0",
        bus.halted, bus.flush, bus.retire_count);
    end
    @(negedge clk); reset = 1'b1;
    #1; checks++;
    if ({bus.rd1, bus.rd2} !== 2'b11) begin
      errors++; $display("FAIL halt_resume_rd: got %b expected 11", {bus.rd1, bus.rd2});
    end
    @(posedge clk); #1; clear_heads(); exp_cnt += 2;
    checks++;
    if (bus.retire_count !== exp_cnt) begin
      errors++; $display("FAIL halt_resume_count: got %0d expected %0d", bus.retire_count, exp_cnt);
    end
  endtask

  task automatic test_halt_misp();
    @(negedge clk);
    set_h1(1, 1, 1, 1, 0, 5'd0, 6'd0, 6'd0, 64'h2000);
    set_h2(1, 1, 0, 0, 1, 5'd3, 6'd1, 6'd2, 64'd0);
    @(posedge clk); #1; exp_cnt += 1;
    set_h1(1, 1, 0, 0, 1, 5'd3, 6'd1, 6'd2, 64'd0);
    checks++;
    if ({bus.flush, bus.halted, bus.redirect_en, bus.redirect_pc} !== {3'b111, 64'h2000}) begin
      errors++; $display("FAIL hm_first: flush %b halted %b redir %b pc %0h expected 1 1 1 2000",
        bus.flush, bus.halted, bus.redirect_en, bus.redirect_pc);
    end
    @(posedge clk); #1; checks++;
    if ({bus.flush, bus.halted, bus.redirect_en} !== 3'b110) begin
      errors++; $display("FAIL hm_second: flush %b halted %b redir %b expected 110",
        bus.flush, bus.halted, bus.redirect_en);
    end
    @(posedge clk); #1; checks++;
    if ({bus.flush, bus.halted, bus.rd1, bus.rd2, bus.retire_count} !== {4'b0100, exp_cnt}) begin
      errors++; $display("FAIL hm_parked: flush %b halted %b rd %b%b count %0d expected 0 1 00 %0d",
        bus.flush, bus.halted, bus.rd1, bus.rd2, bus.retire_count, exp_cnt);
    end
    clear_heads();
  endtask

  initial begin
    test_reset();
    test_dual_retire();
    test_partial();
    test_same_dest();
    test_mispredict();
    test_zero_reg();
    test_halt();
    test_halt_misp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
